// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and the control decoder.
// The opcode lives in the top four bits of every machine word.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int OPCODE_W = 4;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;
  localparam logic [8:0] NOP_INSTR  = 9'h1E0;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_BNE = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'b1111;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [8:0] instr);
    return instr[8 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of control, instruction-memory and decoder signals around the fetch sequencer.
// master is the sequencer side; slave is the surrounding core / testbench.
interface fetch_sequencer_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  import fetch_pkg::*;

  logic               start;
  logic [PC_W-1:0]    start_addr;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] instr_out;
  logic [3:0]         opcode;
  logic               valid;
  logic               done;
  logic [CNT_W-1:0]   cycle_count;
  state_t             state;

  // valid has no ready partner: the decoder consumes instr_out in every cycle
  // valid=1, and stall is the only back-pressure (it freezes the PC).
  modport master (
    input  start, start_addr, imem_data, stall, branch_taken, branch_target,
    output imem_addr, instr_out, opcode, valid, done, cycle_count, state
  );

  modport slave (
    output start, start_addr, imem_data, stall, branch_taken, branch_target,
    input  imem_addr, instr_out, opcode, valid, done, cycle_count, state
  );
endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter with load / hold / branch / increment selection.
// Increment wraps modulo 2^PC_W without any flag.
module pc_reg #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_addr,
  input  logic            hold,
  input  logic            branch,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (hold) begin
      pc <= pc;
    end else if (branch) begin
      pc <= target;
    end else begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, gates instructions to the decoder,
// detects HALT and counts RUN cycles with saturation.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    pc;
  logic               is_halt;
  logic               pc_load;
  logic               pc_hold;
  logic               pc_branch;
  logic               valid_c;
  logic [INSTR_W-1:0] instr_c;
  logic [CNT_W-1:0]   cnt;

  assign is_halt = (state == ST_RUN) && (bus.imem_data == INSTR_W'(HALT_INSTR));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_RUN;
      ST_RUN:    if (is_halt)   state_nxt = ST_HALTED;
      ST_HALTED: if (bus.start) state_nxt = ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // HALT outranks stall and branch, so the PC keeps pointing at the HALT word.
  always_comb begin
    pc_load   = 1'b0;
    pc_hold   = 1'b1;
    pc_branch = 1'b0;
    valid_c   = 1'b0;
    instr_c   = INSTR_W'(NOP_INSTR);
    case (state)
      ST_RUN: begin
        valid_c = 1'b1;
        instr_c = bus.imem_data;
        if (!is_halt && !bus.stall) begin
          pc_hold   = 1'b0;
          pc_branch = bus.branch_taken;
        end
      end
      ST_IDLE, ST_HALTED: pc_load = bus.start;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != ST_RUN) begin
      if (bus.start) cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  pc_reg #(.PC_W(PC_W)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_addr (bus.start_addr),
    .hold      (pc_hold),
    .branch    (pc_branch),
    .target    (bus.branch_target),
    .pc        (pc)
  );

  assign bus.imem_addr   = pc;
  assign bus.instr_out   = instr_c;
  assign bus.opcode      = instr_c[INSTR_W-1 -: 4];
  assign bus.valid       = valid_c;
  assign bus.done        = (state == ST_HALTED);
  assign bus.cycle_count = cnt;
  assign bus.state       = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed test-plan cases with literal
// expectations, then randomized stimulus against a cycle-level behavioural model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int DEPTH   = 1 << PC_W;

  logic clk;
  logic rst_n;
  logic [INSTR_W-1:0] rom [DEPTH];

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_data = rom[bus.imem_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  bit chk_en;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // behavioural model: running / halted flags, pc and count as plain integers
  bit m_run;
  bit m_halt;
  int m_pc;
  int m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_halt = 0; m_pc = 0; m_cnt = 0;
    end else if (m_run) begin
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (rom[m_pc] == 9'h1FF) begin
        m_run = 0; m_halt = 1;
      end else if (bus.stall) begin
        m_pc = m_pc;
      end else if (bus.branch_taken) begin
        m_pc = int'(bus.branch_target);
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end else if (bus.start) begin
      m_run = 1; m_halt = 0; m_pc = int'(bus.start_addr); m_cnt = 0;
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [8:0] e_instr;
      logic [1:0] e_state;
      e_instr = m_run ? rom[m_pc] : 9'h1E0;
      e_state = m_run ? ST_RUN : (m_halt ? ST_HALTED : ST_IDLE);
      chk("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
      chk("valid",       32'(bus.valid),       32'(m_run));
      chk("instr_out",   32'(bus.instr_out),   32'(e_instr));
      chk("opcode",      32'(bus.opcode),      32'(e_instr[8:5]));
      chk("done",        32'(bus.done),        32'(m_halt));
      chk("cycle_count", 32'(bus.cycle_count), 32'(m_cnt));
      chk("state",       32'(bus.state),       32'(e_state));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input int sa, input bit stl, input bit bt, input int tgt);
    bus.start         = st;
    bus.start_addr    = PC_W'(sa);
    bus.stall         = stl;
    bus.branch_taken  = bt;
    bus.branch_target = PC_W'(tgt);
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_en = 0;
    for (int i = 0; i < DEPTH; i++) rom[i] = {OP_ADD, 5'(i)};
    rom[3] = 9'h1FF;
    rom[5] = {OP_BEQ, 5'd2};
    rom[8] = 9'h1FF;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_cnt",   32'(bus.cycle_count), 32'd0);
    chk("rst_instr", 32'(bus.instr_out), 32'h1E0);

    // three ADDs then HALT from address 0
    drive(1, 0, 0, 0, 0);
    tick();
    chk("p1_addr0", 32'(bus.imem_addr), 32'd0);
    chk("p1_valid", 32'(bus.valid), 32'd1);
    drive(0, 0, 0, 0, 0);
    for (int a = 1; a <= 3; a++) begin
      tick();
      chk("p1_addr", 32'(bus.imem_addr), 32'(a));
      chk("p1_valid", 32'(bus.valid), 32'd1);
    end
    tick();
    chk("p1_done",  32'(bus.done), 32'd1);
    chk("p1_cnt",   32'(bus.cycle_count), 32'd4);
    chk("p1_instr", 32'(bus.instr_out), 32'h1E0);

    // branch at 5: taken -> 2, then back to 5 and not taken -> 6
    drive(1, 5, 0, 1, 2);
    tick();
    drive(0, 0, 0, 1, 2);
    tick();
    chk("br_taken", 32'(bus.imem_addr), 32'd2);
    drive(0, 0, 0, 1, 5);
    tick();
    drive(0, 0, 0, 0, 2);
    tick();
    chk("br_not_taken", 32'(bus.imem_addr), 32'd6);
    tick();
    chk("stall_pc7", 32'(bus.imem_addr), 32'd7);
    chk("stall_cnt0", 32'(bus.cycle_count), 32'd4);
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", 32'(bus.imem_addr), 32'd7);
    end
    chk("stall_cnt3", 32'(bus.cycle_count), 32'd7);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("stall_pc8", 32'(bus.imem_addr), 32'd8);
    tick();
    chk("halt8_done", 32'(bus.done), 32'd1);

    // wrap from 1023
    drive(1, 1023, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("wrap_addr", 32'(bus.imem_addr), 32'd0);
    chk("wrap_done", 32'(bus.done), 32'd0);
    tick(); tick(); tick();
    chk("hsb_pc3", 32'(bus.imem_addr), 32'd3);
    drive(0, 0, 1, 1, 9);
    tick();
    chk("hsb_done", 32'(bus.done), 32'd1);
    chk("hsb_pc",   32'(bus.imem_addr), 32'd3);
    drive(0, 0, 0, 0, 0);

    // reset mid-RUN at pc=12
    drive(1, 12, 0, 0, 0);
    tick();
    chk("mid_pc12", 32'(bus.imem_addr), 32'd12);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_pc",    32'(bus.imem_addr), 32'd0);
    chk("mid_valid", 32'(bus.valid), 32'd0);
    chk("mid_done",  32'(bus.done), 32'd0);
    chk("mid_cnt",   32'(bus.cycle_count), 32'd0);

    // restart from HALTED at 40, then run long enough to saturate
    drive(1, 3, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("rs_halted", 32'(bus.done), 32'd1);
    drive(1, 40, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("rs_done",  32'(bus.done), 32'd0);
    chk("rs_cnt",   32'(bus.cycle_count), 32'd0);
    chk("rs_addr",  32'(bus.imem_addr), 32'd40);
    chk("rs_valid", 32'(bus.valid), 32'd1);
    repeat (300) tick();
    chk("sat_cnt",  32'(bus.cycle_count), 32'(CNT_MAX));
    chk("sat_addr", 32'(bus.imem_addr), 32'd340);

    // randomized phase
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < DEPTH; i++)
        rom[i] = ($urandom_range(0, 11) == 0) ? 9'h1FF : 9'($urandom);
      for (int c = 0; c < 500; c++) begin
        rst_n = ($urandom_range(0, 99) != 0);
        drive(($urandom_range(0, 7) == 0), $urandom_range(0, DEPTH - 1),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
              $urandom_range(0, DEPTH - 1));
        tick();
      end
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
